// File: rtl/divclk_monitor.sv
// divclk_monitor: measures clk cycles across PERIODS div_clk periods and
// qualifies the divided clock with a lock indication and a sticky error flag.
//
// Ports:
//   clk        in   source clock (also drives the divider under test)
//   rst        in   asynchronous active-low reset
//   en         in   monitor enable, level-sensitive
//   div_clk    in   divided clock under test, treated as asynchronous
//   err_clr    in   single-cycle clear of err (a same-cycle error wins)
//   meas_cnt   out  last completed window length in clk cycles
//   meas_valid out  one-cycle pulse when meas_cnt updates
//   locked     out  LOCK_N consecutive good windows seen
//   err        out  sticky error: bad window or rise timeout

module divclk_monitor #(
    parameter int CNT_W   = 16,
    parameter int PERIODS = 2,
    parameter int EXP_CNT = 7,
    parameter int TOL     = 1,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_clk,
    input  logic             err_clr,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             locked,
    output logic             err
);

    localparam int PW = $clog2(PERIODS + 1);
    localparam int GW = $clog2(LOCK_N + 1);

    localparam logic [PW-1:0]           PER_LAST = PW'(PERIODS - 1);
    localparam logic [GW-1:0]           LOCK_V   = GW'(LOCK_N);
    localparam logic [CNT_W-1:0]        TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic signed [CNT_W:0]   EXP_S    = (CNT_W + 1)'(EXP_CNT);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W + 1)'(TOL);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEAS
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic [CNT_W-1:0] cyc_q;
    logic [CNT_W-1:0] tmo_q;
    logic [PW-1:0]    per_q;
    logic [GW-1:0]    good_q;
    logic [CNT_W-1:0] meas_cnt_q;
    logic             valid_q;
    logic             locked_q;
    logic             err_q;

    logic             rise;
    logic [CNT_W-1:0] win_cnt_d;
    logic signed [CNT_W:0] diff;
    logic             win_good;
    logic             tmo_hit;
    logic [GW-1:0]    good_d;

    always_comb begin
        rise = sync2_q & ~sync3_q;
        // Length of the window if it closes this cycle: cyc_q counts the
        // edges already elapsed since the opening rise, this edge adds one.
        win_cnt_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        diff = $signed({1'b0, win_cnt_d}) - EXP_S;
        win_good = (diff <= TOL_S) && (diff >= -TOL_S);
        // A rise on the timeout cycle takes priority over the timeout.
        tmo_hit = !rise && (tmo_q == TMO_LAST);
        good_d = (good_q == LOCK_V) ? good_q : good_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            cyc_q      <= '0;
            tmo_q      <= '0;
            per_q      <= '0;
            good_q     <= '0;
            meas_cnt_q <= '0;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q <= div_clk;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            valid_q <= 1'b0;
            // Any error set below overrides this clear.
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (!en) begin
                state_q  <= IDLE;
                locked_q <= 1'b0;
                good_q   <= '0;
                cyc_q    <= '0;
                tmo_q    <= '0;
                per_q    <= '0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        state_q <= ARM;
                        tmo_q   <= '0;
                    end
                    ARM: begin
                        if (rise) begin
                            state_q <= MEAS;
                            cyc_q   <= '0;
                            per_q   <= '0;
                            tmo_q   <= '0;
                        end else if (tmo_hit) begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                            tmo_q    <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    MEAS: begin
                        cyc_q <= win_cnt_d;
                        if (rise) begin
                            tmo_q <= '0;
                            if (per_q == PER_LAST) begin
                                // Close and reopen on the same rise.
                                per_q      <= '0;
                                cyc_q      <= '0;
                                meas_cnt_q <= win_cnt_d;
                                valid_q    <= 1'b1;
                                if (win_good) begin
                                    good_q   <= good_d;
                                    locked_q <= (good_d == LOCK_V);
                                end else begin
                                    good_q   <= '0;
                                    locked_q <= 1'b0;
                                    err_q    <= 1'b1;
                                end
                            end else begin
                                per_q <= per_q + 1'b1;
                            end
                        end else if (tmo_hit) begin
                            state_q  <= ARM;
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                            good_q   <= '0;
                            tmo_q    <= '0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign meas_cnt   = meas_cnt_q;
    assign meas_valid = valid_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

// File: tb/tb_divclk_monitor.sv
// tb_divclk_monitor: drives div_clk waveforms at half-clk resolution,
// predicts each measured window from rise timestamps, checks via scoreboard.

module tb_divclk_monitor;

    localparam int CNT_W   = 16;
    localparam int PERIODS = 2;
    localparam int EXP_CNT = 7;
    localparam int TOL     = 1;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             div_clk = 1'b0;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_valid;
    logic             locked;
    logic             err;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int cnt;
        bit lck;
        bit er;
    } exp_t;

    exp_t q[$];

    // Reference model state, in terms of rise timestamps (clk edge numbers).
    bit m_en = 0;
    bit m_open = 0;
    int m_t0 = 0;
    int m_np = 0;
    int m_good = 0;
    bit m_err = 0;
    int m_last = 0;
    bit clr_on_bad = 0;

    divclk_monitor #(
        .CNT_W(CNT_W), .PERIODS(PERIODS), .EXP_CNT(EXP_CNT),
        .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .div_clk(div_clk),
        .err_clr(err_clr), .meas_cnt(meas_cnt),
        .meas_valid(meas_valid), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // A rise seen by the clk edge at number c (the edge where the monitor
    // acts on it). Returns 1 when it closes a window; pushes the expectation.
    function automatic bit model_rise(input int c, output bit bad);
        int d;
        bad = 0;
        if (!m_en) return 0;
        if (!m_open) begin
            m_open = 1;
            m_t0 = c;
            m_np = 0;
            return 0;
        end
        m_np++;
        if (m_np < PERIODS) return 0;
        d = c - m_t0;
        if (d >= EXP_CNT - TOL && d <= EXP_CNT + TOL) begin
            if (m_good < LOCK_N) m_good++;
        end else begin
            m_good = 0;
            m_err = 1;
            bad = 1;
        end
        m_last = d;
        q.push_back('{c, d, m_good == LOCK_N, m_err});
        m_t0 = c;
        m_np = 0;
        return 1;
    endfunction

    task automatic hstep();
        @(clk);
        #2;
    endtask

    task automatic pulse_clr();
        @(posedge clk);
        @(posedge clk);
        #2 err_clr = 1'b1;
        @(posedge clk);
        #2 err_clr = 1'b0;
    endtask

    // Rise driven after edge n is first sampled at n+1 and acted on at n+3.
    task automatic drise(output bit closing, output int c);
        bit bad;
        div_clk = 1'b1;
        c = cyc + 3;
        closing = model_rise(c, bad);
        if (closing && bad && clr_on_bad) begin
            fork
                pulse_clr();
            join_none
        end
    endtask

    task automatic period(int hi, int lo);
        bit cl;
        int c;
        drise(cl, c);
        repeat (hi) hstep();
        div_clk = 1'b0;
        repeat (lo) hstep();
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " meas_cnt"}, meas_cnt, 0);
        chk({tag, " meas_valid"}, meas_valid, 0);
        chk({tag, " locked"}, locked, 0);
        chk({tag, " err"}, err, 0);
    endtask

    // Rises until one with the requested closing status; then div_clk low.
    task automatic rise_until(bit want_close, output int tc);
        bit cl;
        int c;
        cl = !want_close;
        while (cl != want_close) begin
            drise(cl, c);
            tc = c;
            repeat (3) hstep();
            div_clk = 1'b0;
            if (cl != want_close) repeat (4) hstep();
        end
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("missed meas_valid at cycle", 0, e.cyc);
            end
            if (rst && meas_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected meas_valid", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("valid cycle", cyc, e.cyc);
                    chk("meas_cnt", meas_cnt, e.cnt);
                    chk("locked at valid", locked, e.lck);
                    chk("err at valid", err, e.er);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int tc;
        int tot;
        int hi;
        #1 rst = 1'b0;
        hstep();
        chk_zero("reset");
        repeat (2) period(3, 4);
        rst = 1'b1;
        repeat (8) period(3, 4);
        chk_zero("idle en=0");

        // Nominal divide-by-3.5.
        repeat (8) hstep();
        en = 1'b1;
        m_en = 1;
        repeat (4) hstep();
        repeat (290) period(3, 4);

        // One stretched period (5.5 clk) then relock.
        period(3, 8);
        repeat (10) period(3, 4);

        // Random periods, 2.5 to 5.5 clk, random duty.
        repeat (60) begin
            tot = $urandom_range(5, 11);
            hi = $urandom_range(2, tot - 2);
            period(hi, tot - hi);
        end
        repeat (12) period(3, 4);

        // Timeout after lock; err_clr alone first so the set is visible.
        rise_until(1, tc);
        while (cyc < tc + 1) @(posedge clk);
        #1;
        chk("locked before timeout", locked, m_good == LOCK_N);
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("err after lone err_clr", err, 0);
        err_clr = 1'b0;
        m_err = 0;
        while (cyc < tc + TIMEOUT - 1) begin
            @(posedge clk);
            #1;
        end
        chk("err one cycle before timeout", err, 0);
        chk("locked one cycle before timeout", locked, 1);
        @(posedge clk);
        #1;
        chk("err at timeout", err, 1);
        chk("locked at timeout", locked, 0);
        m_err = 1;
        m_good = 0;
        m_open = 0;
        #1 err_clr = 1'b1;
        @(posedge clk);
        #1;
        chk("err after err_clr in ARM", err, 0);
        err_clr = 1'b0;
        m_err = 0;
        hstep();
        repeat (12) period(3, 4);

        // Bad window with err_clr on the same cycle.
        clr_on_bad = 1;
        period(3, 8);
        repeat (3) period(3, 4);
        clr_on_bad = 0;
        repeat (10) period(3, 4);

        // Drop en mid-window.
        rise_until(0, tc);
        while (cyc < tc + 1) @(posedge clk);
        #1;
        chk("locked before en drop", locked, m_good == LOCK_N);
        #1 en = 1'b0;
        m_en = 0;
        m_open = 0;
        m_good = 0;
        @(posedge clk);
        #1;
        chk("locked after en drop", locked, 0);
        chk("meas_cnt after en drop", meas_cnt, m_last);
        repeat (3) @(posedge clk);
        #1;
        chk("meas_cnt holds in idle", meas_cnt, m_last);
        chk("err holds in idle", err, m_err);
        en = 1'b1;
        m_en = 1;
        repeat (2) @(posedge clk);
        hstep();
        repeat (12) period(3, 4);

        // Asynchronous reset mid-MEAS.
        rise_until(0, tc);
        while (cyc < tc + 2) @(posedge clk);
        #1;
        chk("meas_cnt before async reset", meas_cnt, m_last);
        chk("locked before async reset", locked, m_good == LOCK_N);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk_zero("async reset");
        m_open = 0;
        m_good = 0;
        m_err = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
